// File: rtl/app_sched_pkg.sv
// Shared definitions for app_scheduler: FSM state encodings, counter width and
// helpers that derive the address width and the write-flag offset from the configuration.
package app_sched_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RUN     = 3'd1;
    localparam state_t ST_COMPUTE = 3'd2;
    localparam state_t ST_ISSUE   = 3'd3;
    localparam state_t ST_WAIT    = 3'd4;
    localparam state_t ST_DELIVER = 3'd5;

    localparam int CNT_WIDTH = 14;

    // Supported node counts only; anything else falls back to the largest network.
    function automatic int addr_width_of(input int n);
        case (n)
            4:       return 2;
            16:      return 4;
            64:      return 6;
            256:     return 8;
            default: return 10;
        endcase
    endfunction

    // Request/result word layout: {flag, addr, data}. The flag sits just above addr and data.
    function automatic int wr_bit_of(input int addr_width, input int data_width);
        return addr_width + data_width;
    endfunction

    // The address field starts just above the data field.
    function automatic int addr_lsb_of(input int data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/app_sched_cycle_counter.sv
// Loadable 14-bit down-counter that paces the COMPUTE state of app_scheduler.
// done_o is high while the count equals 1, which is the last compute cycle.
module app_sched_cycle_counter
    import app_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    input  logic                 dec_i,
    output logic                 done_o
);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_WIDTH'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == CNT_WIDTH'(1));

endmodule

// File: rtl/app_scheduler.sv
// Per-node scheduler between the user application and the network port.
// Optional statistics outputs are enabled with the APP_SCHED_STATS_EN macro.
module app_scheduler
    import app_sched_pkg::*;
#(
    parameter  int N          = 1024,
    parameter  int I          = 0,
    parameter  int DATA_WIDTH = 32,
    localparam int ADDR_WIDTH = addr_width_of(N),
    localparam int WIDTH      = ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] compute_cycles,
    input  logic [WIDTH:0]       app_request,
    output logic                 runnable,
    output logic [WIDTH:0]       nanci_result,
    output logic                 net_req_valid,
    input  logic                 net_req_ready,
    output logic [WIDTH:0]       net_req,
    input  logic                 net_resp_valid,
    input  logic [WIDTH-1:0]     net_resp,
`ifdef APP_SCHED_STATS_EN
    output logic [31:0]          stat_txns,
    output logic [31:0]          stat_wait_cycles,
`endif
    output logic                 busy
);

    localparam int WR_BIT = wr_bit_of(ADDR_WIDTH, DATA_WIDTH);

    if ((I < 0) || (I >= N)) begin : g_bad_node_index
        $error("app_scheduler: node index I is outside 0..N-1");
    end

    state_t               state_q, state_d;
    logic [WIDTH:0]       net_req_q, net_req_d;
    logic [WIDTH-1:0]     payload_q, payload_d;
    logic                 res_valid_q, res_valid_d;
    logic                 cnt_load, cnt_dec, cnt_done;
    logic [CNT_WIDTH-1:0] cnt_load_val;

    // A declared latency of zero still spends one cycle in COMPUTE.
    assign cnt_load_val = (compute_cycles == '0) ? CNT_WIDTH'(1) : compute_cycles;

    app_sched_cycle_counter u_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .done_o     (cnt_done)
    );

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case infers a latch.
        state_d   = state_q;
        net_req_d = net_req_q;
        payload_d = payload_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_load = 1'b1;
                state_d  = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                cnt_dec = 1'b1;
                if (cnt_done) begin
                    net_req_d = app_request;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Writes complete locally on acceptance; reads wait for the responder.
                if (net_req_ready) begin
                    if (net_req_q[WR_BIT]) begin
                        payload_d = net_req_q[WIDTH-1:0];
                        state_d   = ST_DELIVER;
                    end else begin
                        state_d   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (net_resp_valid) begin
                    payload_d = net_resp;
                    state_d   = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                state_d = start ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        res_valid_d = (state_d == ST_DELIVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            net_req_q   <= '0;
            payload_q   <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            net_req_q   <= net_req_d;
            payload_q   <= payload_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Decoded from the state register so reset clears them without waiting for a clock.
    assign runnable      = (state_q == ST_RUN);
    assign net_req_valid = (state_q == ST_ISSUE);
    assign busy          = (state_q != ST_IDLE);
    assign net_req       = net_req_q;
    assign nanci_result  = {res_valid_q, payload_q};

`ifdef APP_SCHED_STATS_EN
    logic [31:0] stat_txns_q, stat_wait_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_txns_q <= '0;
            stat_wait_q <= '0;
        end else begin
            if ((state_q == ST_DELIVER) && (stat_txns_q != '1)) begin
                stat_txns_q <= stat_txns_q + 32'd1;
            end
            if (((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && (stat_wait_q != '1)) begin
                stat_wait_q <= stat_wait_q + 32'd1;
            end
        end
    end

    assign stat_txns        = stat_txns_q;
    assign stat_wait_cycles = stat_wait_q;
`endif

endmodule

// File: tb/tb_app_scheduler.sv
// Self-checking bench for app_scheduler (N=16): directed transaction table, reset
// corner cases and randomized transactions against a transaction-level timing model.
module tb_app_scheduler;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int W  = AW + DW;

    typedef struct {
        int           cc;
        bit           wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int           rdelay;      // cycles with ready low while in ISSUE
        int           resp_delay;  // cycles from handshake to response (reads)
        logic [AW-1:0] raddr;
        logic [DW-1:0] rdata;
        bit           stray;       // response strobes during COMPUTE and ISSUE
        int           drop_k;      // cycle index where start falls, -1 = never
        int           exp_deliver; // cycle index of DELIVER relative to RUN
        logic [W:0]   exp_result;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [13:0]   compute_cycles;
    logic [W:0]    app_request;
    logic          runnable;
    logic [W:0]    nanci_result;
    logic          net_req_valid;
    logic          net_req_ready;
    logic [W:0]    net_req;
    logic          net_resp_valid;
    logic [W-1:0]  net_resp;
    logic          busy;
`ifdef APP_SCHED_STATS_EN
    logic [31:0]   stat_txns;
    logic [31:0]   stat_wait_cycles;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int txn_id = -1;
    int cyc = 0;
    logic [W-1:0] last_payload = '0;
    int m_txns = 0;
    int m_wait = 0;

    app_scheduler #(.N(16), .I(0), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .compute_cycles (compute_cycles),
        .app_request    (app_request),
        .runnable       (runnable),
        .nanci_result   (nanci_result),
        .net_req_valid  (net_req_valid),
        .net_req_ready  (net_req_ready),
        .net_req        (net_req),
        .net_resp_valid (net_resp_valid),
        .net_resp       (net_resp),
`ifdef APP_SCHED_STATS_EN
        .stat_txns        (stat_txns),
        .stat_wait_cycles (stat_wait_cycles),
`endif
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (txn %0d cycle %0d)", name, got, exp, txn_id, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: phase lengths follow directly from the protocol rules.
    function automatic int model_deliver(input vec_t v);
        int issue_k;
        issue_k = 1 + ((v.cc == 0) ? 1 : v.cc);
        return v.wr ? (issue_k + v.rdelay + 1) : (issue_k + v.rdelay + v.resp_delay + 1);
    endfunction

    function automatic logic [W:0] model_result(input vec_t v);
        return v.wr ? {1'b1, v.addr, v.data} : {1'b1, v.raddr, v.rdata};
    endfunction

    task automatic reset_model();
        last_payload = '0;
        m_txns = 0;
        m_wait = 0;
    endtask

    // Entered with the DUT one cycle before RUN; returns after DELIVER (and one IDLE cycle if start fell).
    task automatic run_txn(input vec_t v);
        int issue_k, hs_k, resp_k;
        logic [W:0] exp_req;
        bit st;
        issue_k = 1 + ((v.cc == 0) ? 1 : v.cc);
        hs_k    = issue_k + v.rdelay;
        resp_k  = hs_k + v.resp_delay;
        exp_req = {v.wr, v.addr, v.data};
        st = 1'b1;
        for (int k = 0; k <= v.exp_deliver; k++) begin
            step();
            cyc = k;
            check("runnable", 64'(runnable), 64'(k == 0));
            check("busy", 64'(busy), 64'd1);
            check("net_req_valid", 64'(net_req_valid), 64'((k >= issue_k) && (k <= hs_k)));
            check("result_valid", 64'(nanci_result[W]), 64'(k == v.exp_deliver));
            if (k == 0) check("result_hold", 64'(nanci_result), 64'({1'b0, last_payload}));
            if (k >= issue_k) check("net_req", 64'(net_req), 64'(exp_req));
            if (k == v.exp_deliver) check("nanci_result", 64'(nanci_result), 64'(v.exp_result));

            if (k == 0) begin
                compute_cycles = 14'(v.cc);
                app_request    = exp_req;
            end else begin
                compute_cycles = 14'($urandom());
                if (k >= issue_k) app_request = 37'({$urandom(), $urandom()});
            end
            net_req_ready = (k >= hs_k) ? 1'b1 : ((k < issue_k) ? 1'($urandom_range(0, 1)) : 1'b0);
            if (!v.wr && (k == resp_k)) begin
                net_resp_valid = 1'b1;
                net_resp       = {v.raddr, v.rdata};
            end else begin
                net_resp_valid = v.stray && (k >= 1) && (k <= hs_k);
                net_resp       = 36'({$urandom(), $urandom()});
            end
            if ((v.drop_k >= 0) && (k >= v.drop_k)) st = 1'b0;
            start = st;
        end
        m_txns++;
        m_wait += v.exp_deliver - issue_k;
        last_payload = v.exp_result[W-1:0];
        if (!st) begin
            step();
            cyc = v.exp_deliver + 1;
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_runnable", 64'(runnable), 64'd0);
            check("idle_result", 64'(nanci_result), 64'({1'b0, last_payload}));
            start = 1'b1;
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{5, 1'b0, 4'hF, 32'h0, 0, 3, 4'hF, 32'hDEAD, 1'b0, -1, 10, {1'b1, 4'hF, 32'h0000DEAD}};
        vecs[1] = vecs[0];
        vecs[2] = vecs[0];
        vecs[3] = '{0, 1'b1, 4'h3, 32'h12345678, 0, 1, 4'h0, 32'h0, 1'b0, -1, 3, {1'b1, 4'h3, 32'h12345678}};
        vecs[4] = '{2, 1'b1, 4'h9, 32'hA5A5A5A5, 7, 1, 4'h0, 32'h0, 1'b0, -1, 11, {1'b1, 4'h9, 32'hA5A5A5A5}};
        vecs[5] = '{3, 1'b0, 4'h7, 32'h0BAD0BAD, 2, 2, 4'hC, 32'hCAFEF00D, 1'b1, 7, 9, {1'b1, 4'hC, 32'hCAFEF00D}};
        vecs[6] = '{1, 1'b1, 4'h5, 32'h0000FFFF, 1, 1, 4'h0, 32'h0, 1'b1, -1, 4, {1'b1, 4'h5, 32'h0000FFFF}};

        rst = 1'b0;
        start = 1'b0;
        compute_cycles = '0;
        app_request = '0;
        net_req_ready = 1'b0;
        net_resp_valid = 1'b0;
        net_resp = '0;
        reset_model();

        // Reset values, then release with start high and interrupt mid-COMPUTE.
        step();
        step();
        check("rst_runnable", 64'(runnable), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_net_req_valid", 64'(net_req_valid), 64'd0);
        check("rst_net_req", 64'(net_req), 64'd0);
        check("rst_nanci_result", 64'(nanci_result), 64'd0);
        rst = 1'b1;
        start = 1'b1;
        compute_cycles = 14'd8;
        app_request = {1'b1, 4'h2, 32'h00001234};
        check("rel_idle_runnable", 64'(runnable), 64'd0);
        step();
        check("rel_run_runnable", 64'(runnable), 64'd1);
        step();
        check("rel_compute_runnable", 64'(runnable), 64'd0);
        check("rel_compute_busy", 64'(busy), 64'd1);
        step();
        #2 rst = 1'b0;
        #1;
        check("async_compute_busy", 64'(busy), 64'd0);
        check("async_compute_runnable", 64'(runnable), 64'd0);
        check("async_compute_result", 64'(nanci_result), 64'd0);

        // Release again and reset while a request is being offered.
        step();
        rst = 1'b1;
        compute_cycles = 14'd1;
        check("rel2_idle_busy", 64'(busy), 64'd0);
        step();
        check("rel2_run_runnable", 64'(runnable), 64'd1);
        step();
        step();
        check("issue_valid", 64'(net_req_valid), 64'd1);
        check("issue_net_req", 64'(net_req), 64'({1'b1, 4'h2, 32'h00001234}));
        #2 rst = 1'b0;
        #1;
        check("async_issue_valid", 64'(net_req_valid), 64'd0);
        check("async_issue_net_req", 64'(net_req), 64'd0);
        check("async_issue_busy", 64'(busy), 64'd0);
        step();
        rst = 1'b1;
        start = 1'b1;
        reset_model();

        for (int t = 0; t < 7; t++) begin
            txn_id = t;
            run_txn(vecs[t]);
`ifdef APP_SCHED_STATS_EN
            if (t == 2) begin
                check("stat_txns_3reads", 64'(stat_txns), 64'd3);
                check("stat_wait_3reads", 64'(stat_wait_cycles), 64'd12);
            end
`endif
        end

        for (int t = 0; t < 40; t++) begin
            vec_t v;
            v.cc         = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 40) : $urandom_range(0, 6);
            v.wr         = 1'($urandom_range(0, 1));
            v.addr       = 4'($urandom());
            v.data       = $urandom();
            v.rdelay     = $urandom_range(0, 4);
            v.resp_delay = $urandom_range(1, 4);
            v.raddr      = 4'($urandom());
            v.rdata      = $urandom();
            v.stray      = 1'($urandom_range(0, 1));
            v.drop_k     = -1;
            v.exp_deliver = model_deliver(v);
            v.exp_result  = model_result(v);
            if ($urandom_range(0, 3) == 0) v.drop_k = $urandom_range(1, v.exp_deliver);
            txn_id = 100 + t;
            run_txn(v);
        end

`ifdef APP_SCHED_STATS_EN
        step();
        check("stat_txns_total", 64'(stat_txns), 64'(m_txns));
        check("stat_wait_total", 64'(stat_wait_cycles), 64'(m_wait));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/app_scheduler.md
Name: app_scheduler

Overview:
- Per-node controller that sits directly beside the user `application` block and the NANCI network port.
- Pulses `runnable` to the application and waits out the application's declared `compute_cycles`.
- Captures the resulting `app_request`, issues it into the network with a valid/ready handshake, and returns the network response to the application as `nanci_result`.
- One instance per node; node index `I`.

Parameters:
- N, 1024, number of nodes; legal values 4/16/64/256/1024.
- I, 0, this node's index.
- DATA_WIDTH, 32, payload width.
- ADDR_WIDTH, derived (not overridable), log2(N): 10/8/6/4/2.
- WIDTH, derived, ADDR_WIDTH+DATA_WIDTH.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  level; node may begin or continue operation while high.
- compute_cycles  input  14  application's declared compute latency.
- app_request  input  WIDTH+1  from the application:
  - [WIDTH] = write flag (0 = read).
  - [WIDTH-1:DATA_WIDTH] = target node address.
  - [DATA_WIDTH-1:0] = data.
- runnable  output  1  one-cycle enable pulse to the application.
- nanci_result  output  WIDTH+1  to the application:
  - [WIDTH] = valid.
  - [WIDTH-1:DATA_WIDTH] = responder address.
  - [DATA_WIDTH-1:0] = data.
- net_req_valid  output  1  request valid toward the network.
- net_req_ready  input  1  network accepts the request.
- net_req  output  WIDTH+1  registered copy of the captured app_request.
- net_resp_valid  input  1  network response strobe.
- net_resp  input  WIDTH  {responder addr, data}.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - runnable, net_req_valid, busy = 0.
  - net_req, nanci_result = 0.
  - Counter = 0.
- FSM states IDLE, RUN, COMPUTE, ISSUE, WAIT, DELIVER:
  - IDLE: if start, go to RUN next cycle.
  - RUN: runnable = 1 for exactly this cycle. Load counter = max(compute_cycles, 1). Go to COMPUTE.
  - COMPUTE: counter decrements each cycle. At counter == 1, capture app_request into net_req and go to ISSUE. The application registers its request on the RUN edge, so the capture always sees the updated value.
  - ISSUE: net_req_valid = 1 and net_req held stable until net_req_ready is sampled high. On the handshake cycle:
    - read → WAIT.
    - write → DELIVER, with nanci_result = {1, net_req[WIDTH-1:0]}.
  - WAIT: on net_resp_valid, nanci_result = {1, net_resp} and go to DELIVER. Responses arriving in any other state are ignored.
  - DELIVER: nanci_result valid bit is high for exactly this cycle; the payload holds its value afterwards. Then:
    - start high → RUN.
    - start low → IDLE.
- Latency: RUN-to-ISSUE is max(compute_cycles, 1) cycles. A write with net_req_ready already high returns to RUN 2 cycles after entering ISSUE.
- nanci_result[WIDTH] is cleared on every cycle except DELIVER.
- Dropping start mid-transaction does not abort it. The block finishes the transaction and stops at DELIVER→IDLE.
- A net_req_ready / net_resp_valid coincidence in ISSUE: the response is not counted, because ISSUE does not look at net_resp_valid.
- compute_cycles is sampled only in RUN. Changes during COMPUTE are ignored.
- An asynchronous reset in any state returns to IDLE immediately. An in-flight request is dropped and net_req_valid deasserts the same instant.

Optional Feature:
- Macro APP_SCHED_STATS_EN.
- When defined, two extra outputs are added:
  - stat_txns[31:0]: increments on every DELIVER.
  - stat_wait_cycles[31:0]: increments every cycle spent in ISSUE or WAIT.
  - Both reset to 0 and saturate at all-ones.
- When undefined, the ports and counters are absent and function is otherwise identical.

Decomposition:
- Package app_sched_pkg:
  - State enum.
  - ADDR_WIDTH lookup function of N.
  - Field-offset constants (WR_BIT = WIDTH, ADDR_LSB = DATA_WIDTH).
- One natural sub-module, app_sched_cycle_counter: a 14-bit loadable down-counter with a done flag, used by the COMPUTE state.
- The FSM and registers stay in the top level.

Test Plan:
- Reset: assert rst low mid-COMPUTE → all outputs 0 immediately, state IDLE; release with start=1 → runnable pulses on the 2nd cycle after release.
- Read, N=16, I=0, compute_cycles=5, app returns {0, addr 15, data 0}, net_req_ready tied 1, response {addr 15, data 0xDEAD} 3 cycles later → net_req=0x0F_00000000; nanci_result={1,15,0xDEAD} for one cycle; runnable period = 1+5+1+3+1 cycles.
- Write, compute_cycles=0 → treated as 1; net_req captured 1 cycle after runnable; no WAIT state; nanci_result echoes the request with valid=1.
- Backpressure: net_req_ready low for 7 cycles → net_req_valid held high and net_req unchanged across all 7 cycles; handshake on the 8th.
- Stray net_resp_valid in COMPUTE and ISSUE → ignored, no DELIVER; start dropped in WAIT → completes the transaction, then IDLE, busy=0.
- With APP_SCHED_STATS_EN: 3 reads, each with a 4-cycle ISSUE+WAIT span → stat_txns=3, stat_wait_cycles=12.
